softmax_bram_arbiter: RTL and testbench

- Shares the softmax BRAM (write port A, read port B) between the UART host controller and the softmax core's internal datapath.
- Ownership follows i_core_busy. The owner has fixed priority on each port. The non-owner is served only on cycles where the owner is idle on that port.
- BRAM commands are registered. A read-return tag pipeline routes each read beat to the requester that issued it.
- Sits between uart_bram_controller/softmax_core and the BRAM macro.

---
 rtl/softmax_bram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_softmax_bram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_bram_arbiter.sv
// Two-requester arbiter (UART host / softmax core) for the softmax BRAM: write port A, read port B.
// Optional ARB_STARVE_GUARD_EN: bounded wait for the non-owner via per-port wait counters.
module softmax_bram_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 1028,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_core_busy,
    input  logic              i_h_wr_req,
    input  logic [ADDR_W-1:0] i_h_wr_addr,
    input  logic [DATA_W-1:0] i_h_wr_data,
    output logic              o_h_wr_gnt,
    input  logic              i_h_rd_req,
    input  logic [ADDR_W-1:0] i_h_rd_addr,
    output logic              o_h_rd_gnt,
    output logic [DATA_W-1:0] o_h_rd_data,
    output logic              o_h_rd_valid,
    input  logic              i_c_wr_req,
    input  logic [ADDR_W-1:0] i_c_wr_addr,
    input  logic [DATA_W-1:0] i_c_wr_data,
    output logic              o_c_wr_gnt,
    input  logic              i_c_rd_req,
    input  logic [ADDR_W-1:0] i_c_rd_addr,
    output logic              o_c_rd_gnt,
    output logic [DATA_W-1:0] o_c_rd_data,
    output logic              o_c_rd_valid,
    output logic              o_bram_ena,
    output logic              o_bram_wea,
    output logic [ADDR_W-1:0] o_bram_addra,
    output logic [DATA_W-1:0] o_bram_dina,
    output logic              o_bram_enb,
    output logic [ADDR_W-1:0] o_bram_addrb,
    input  logic [DATA_W-1:0] i_bram_doutb,
    output logic              o_owner
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("softmax_bram_arbiter: RD_LAT must be 1..4");
    end
    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("softmax_bram_arbiter: MAX_WAIT must be at least 1");
    end

    logic owner_q;

    logic a_own_req, a_non_req, a_own_gnt, a_non_gnt, a_force;
    logic b_own_req, b_non_req, b_own_gnt, b_non_gnt, b_force;
    logic h_wr_acc, c_wr_acc, h_rd_acc, c_rd_acc;

    logic              ena_q;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              enb_q;
    logic [ADDR_W-1:0] addrb_q, addrb_d;

    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_core_q;
    logic              h_rd_valid_q, c_rd_valid_q;
    logic [DATA_W-1:0] h_rd_data_q, c_rd_data_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) owner_q <= 1'b0;
        else        owner_q <= i_core_busy;
    end

    assign a_own_req = owner_q ? i_c_wr_req : i_h_wr_req;
    assign a_non_req = owner_q ? i_h_wr_req : i_c_wr_req;
    assign b_own_req = owner_q ? i_c_rd_req : i_h_rd_req;
    assign b_non_req = owner_q ? i_h_rd_req : i_c_rd_req;

`ifdef ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_a_q, wait_a_d, wait_b_q, wait_b_d;

    assign a_force = (wait_a_q == WAIT_MAX) & a_non_req;
    assign b_force = (wait_b_q == WAIT_MAX) & b_non_req;

    // Count only denied cycles; an accept or a dropped request restarts the count.
    always_comb begin
        wait_a_d = '0;
        wait_b_d = '0;
        if (a_non_req && !a_non_gnt)
            wait_a_d = (wait_a_q == WAIT_MAX) ? wait_a_q : wait_a_q + 1'b1;
        if (b_non_req && !b_non_gnt)
            wait_b_d = (wait_b_q == WAIT_MAX) ? wait_b_q : wait_b_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wait_a_q <= '0;
            wait_b_q <= '0;
        end else begin
            wait_a_q <= wait_a_d;
            wait_b_q <= wait_b_d;
        end
    end
`else
    assign a_force = 1'b0;
    assign b_force = 1'b0;
`endif

    // Grants are gated by the async reset so nothing is accepted while it is held.
    assign a_own_gnt = i_rst & a_own_req & ~a_force;
    assign a_non_gnt = i_rst & a_non_req & (~a_own_req | a_force);
    assign b_own_gnt = i_rst & b_own_req & ~b_force;
    assign b_non_gnt = i_rst & b_non_req & (~b_own_req | b_force);

    assign o_h_wr_gnt = owner_q ? a_non_gnt : a_own_gnt;
    assign o_c_wr_gnt = owner_q ? a_own_gnt : a_non_gnt;
    assign o_h_rd_gnt = owner_q ? b_non_gnt : b_own_gnt;
    assign o_c_rd_gnt = owner_q ? b_own_gnt : b_non_gnt;

    assign h_wr_acc = i_h_wr_req & o_h_wr_gnt;
    assign c_wr_acc = i_c_wr_req & o_c_wr_gnt;
    assign h_rd_acc = i_h_rd_req & o_h_rd_gnt;
    assign c_rd_acc = i_c_rd_req & o_c_rd_gnt;

    always_comb begin
        addra_d = addra_q;
        dina_d  = dina_q;
        addrb_d = addrb_q;
        if (h_wr_acc) begin
            addra_d = i_h_wr_addr;
            dina_d  = i_h_wr_data;
        end else if (c_wr_acc) begin
            addra_d = i_c_wr_addr;
            dina_d  = i_c_wr_data;
        end
        if (h_rd_acc)      addrb_d = i_h_rd_addr;
        else if (c_rd_acc) addrb_d = i_c_rd_addr;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ena_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
            enb_q   <= 1'b0;
            addrb_q <= '0;
        end else begin
            ena_q   <= h_wr_acc | c_wr_acc;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            enb_q   <= h_rd_acc | c_rd_acc;
            addrb_q <= addrb_d;
        end
    end

    // Tag records who issued each read so a mid-flight ownership change cannot misroute it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tag_vld_q  <= '0;
            tag_core_q <= '0;
        end else begin
            tag_vld_q[0]  <= h_rd_acc | c_rd_acc;
            tag_core_q[0] <= c_rd_acc;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld_q[k]  <= tag_vld_q[k-1];
                tag_core_q[k] <= tag_core_q[k-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            h_rd_valid_q <= 1'b0;
            c_rd_valid_q <= 1'b0;
            h_rd_data_q  <= '0;
            c_rd_data_q  <= '0;
        end else begin
            h_rd_valid_q <= tag_vld_q[RD_LAT-1] & ~tag_core_q[RD_LAT-1];
            c_rd_valid_q <= tag_vld_q[RD_LAT-1] &  tag_core_q[RD_LAT-1];
            if (tag_vld_q[RD_LAT-1] && !tag_core_q[RD_LAT-1]) h_rd_data_q <= i_bram_doutb;
            if (tag_vld_q[RD_LAT-1] &&  tag_core_q[RD_LAT-1]) c_rd_data_q <= i_bram_doutb;
        end
    end

    assign o_bram_ena   = ena_q;
    assign o_bram_wea   = ena_q;
    assign o_bram_addra = addra_q;
    assign o_bram_dina  = dina_q;
    assign o_bram_enb   = enb_q;
    assign o_bram_addrb = addrb_q;
    assign o_h_rd_valid = h_rd_valid_q;
    assign o_h_rd_data  = h_rd_data_q;
    assign o_c_rd_valid = c_rd_valid_q;
    assign o_c_rd_data  = c_rd_data_q;
    assign o_owner      = owner_q;

endmodule

// File: tb/tb_softmax_bram_arbiter.sv
// Randomized bench for softmax_bram_arbiter against a transaction-level reference model
// (grant rules, a reference memory and a queue of expected read returns).
module tb_softmax_bram_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 1028;
    localparam int RD_LAT   = 1;
    localparam int MAX_WAIT = 15;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_core_busy = 1'b0;
    logic              i_h_wr_req = 1'b0, i_h_rd_req = 1'b0, i_c_wr_req = 1'b0, i_c_rd_req = 1'b0;
    logic [ADDR_W-1:0] i_h_wr_addr = '0, i_h_rd_addr = '0, i_c_wr_addr = '0, i_c_rd_addr = '0;
    logic [DATA_W-1:0] i_h_wr_data = '0, i_c_wr_data = '0;
    logic              o_h_wr_gnt, o_h_rd_gnt, o_c_wr_gnt, o_c_rd_gnt;
    logic [DATA_W-1:0] o_h_rd_data, o_c_rd_data;
    logic              o_h_rd_valid, o_c_rd_valid;
    logic              o_bram_ena, o_bram_wea, o_bram_enb, o_owner;
    logic [ADDR_W-1:0] o_bram_addra, o_bram_addrb;
    logic [DATA_W-1:0] o_bram_dina, i_bram_doutb;

    softmax_bram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_core_busy(i_core_busy),
        .i_h_wr_req(i_h_wr_req), .i_h_wr_addr(i_h_wr_addr), .i_h_wr_data(i_h_wr_data),
        .o_h_wr_gnt(o_h_wr_gnt),
        .i_h_rd_req(i_h_rd_req), .i_h_rd_addr(i_h_rd_addr), .o_h_rd_gnt(o_h_rd_gnt),
        .o_h_rd_data(o_h_rd_data), .o_h_rd_valid(o_h_rd_valid),
        .i_c_wr_req(i_c_wr_req), .i_c_wr_addr(i_c_wr_addr), .i_c_wr_data(i_c_wr_data),
        .o_c_wr_gnt(o_c_wr_gnt),
        .i_c_rd_req(i_c_rd_req), .i_c_rd_addr(i_c_rd_addr), .o_c_rd_gnt(o_c_rd_gnt),
        .o_c_rd_data(o_c_rd_data), .o_c_rd_valid(o_c_rd_valid),
        .o_bram_ena(o_bram_ena), .o_bram_wea(o_bram_wea), .o_bram_addra(o_bram_addra),
        .o_bram_dina(o_bram_dina), .o_bram_enb(o_bram_enb), .o_bram_addrb(o_bram_addrb),
        .i_bram_doutb(i_bram_doutb), .o_owner(o_owner)
    );

    always #5 i_clk = ~i_clk;

    // READ_FIRST BRAM whose output is sampled by the arbiter in the enb cycle (RD_LAT = 1)
    logic [DATA_W-1:0] bram_mem [0:(1<<ADDR_W)-1];
    always @(posedge i_clk) if (o_bram_ena && o_bram_wea) bram_mem[o_bram_addra] <= o_bram_dina;
    assign i_bram_doutb = bram_mem[o_bram_addrb];

    typedef struct {
        int                due;
        bit                core;
        logic [DATA_W-1:0] data;
    } ret_t;

    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc = 0;
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    ret_t              ret_q[$];
    bit                m_owner;
    int                m_wa, m_wb;
    bit                g_hw, g_cw, g_hr, g_cr;
    bit                x_ena, x_enb;
    logic [ADDR_W-1:0] x_addra, x_addrb;
    logic [DATA_W-1:0] x_dina, x_h_data, x_c_data;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] v = '0;
        for (int i = 0; i < (DATA_W + 31) / 32; i++) v = {v[DATA_W-33:0], 32'($urandom)};
        return v;
    endfunction

    task automatic model_reset();
        ret_q.delete();
        m_owner = 0; m_wa = 0; m_wb = 0;
        g_hw = 0; g_cw = 0; g_hr = 0; g_cr = 0;
        x_ena = 0; x_enb = 0; x_addra = '0; x_addrb = '0; x_dina = '0;
        x_h_data = '0; x_c_data = '0;
    endtask

    task automatic set_idle();
        i_h_wr_req = 0; i_c_wr_req = 0; i_h_rd_req = 0; i_c_rd_req = 0;
    endtask

    // Advance one clock and compare every registered output with the model.
    task automatic tick();
        bit xhv, xcv;
        @(posedge i_clk);
        cyc++;
        #1;
        xhv = 0; xcv = 0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            if (ret_q[0].core) begin xcv = 1; x_c_data = ret_q[0].data; end
            else               begin xhv = 1; x_h_data = ret_q[0].data; end
            void'(ret_q.pop_front());
        end
        check("owner", o_owner, m_owner);
        check("ena", o_bram_ena, x_ena);
        check("wea", o_bram_wea, x_ena);
        check("addra", o_bram_addra, x_addra);
        check("dina", o_bram_dina, x_dina);
        check("enb", o_bram_enb, x_enb);
        check("addrb", o_bram_addrb, x_addrb);
        check("h_rd_valid", o_h_rd_valid, xhv);
        check("c_rd_valid", o_c_rd_valid, xcv);
        check("h_rd_data", o_h_rd_data, x_h_data);
        check("c_rd_data", o_c_rd_data, x_c_data);
    endtask

    // Called once inputs for the current cycle are driven: check grants, advance the model.
    task automatic eval();
        bit own, oa, na, fa, ob, nb, fb, oga, nga, ogb, ngb;
        #1;
        if (!i_rst) begin
            check("h_wr_gnt_rst", o_h_wr_gnt, 1'b0);
            check("c_wr_gnt_rst", o_c_wr_gnt, 1'b0);
            check("h_rd_gnt_rst", o_h_rd_gnt, 1'b0);
            check("c_rd_gnt_rst", o_c_rd_gnt, 1'b0);
            return;
        end
        own = m_owner;
        oa = own ? i_c_wr_req : i_h_wr_req;
        na = own ? i_h_wr_req : i_c_wr_req;
        ob = own ? i_c_rd_req : i_h_rd_req;
        nb = own ? i_h_rd_req : i_c_rd_req;
        fa = GUARD && (m_wa == MAX_WAIT) && na;
        fb = GUARD && (m_wb == MAX_WAIT) && nb;
        oga = oa && !fa;  nga = na && (!oa || fa);
        ogb = ob && !fb;  ngb = nb && (!ob || fb);
        g_hw = own ? nga : oga;  g_cw = own ? oga : nga;
        g_hr = own ? ngb : ogb;  g_cr = own ? ogb : ngb;
        check("h_wr_gnt", o_h_wr_gnt, g_hw);
        check("c_wr_gnt", o_c_wr_gnt, g_cw);
        check("h_rd_gnt", o_h_rd_gnt, g_hr);
        check("c_rd_gnt", o_c_rd_gnt, g_cr);
        m_wa = (na && !nga) ? ((m_wa < MAX_WAIT) ? m_wa + 1 : MAX_WAIT) : 0;
        m_wb = (nb && !ngb) ? ((m_wb < MAX_WAIT) ? m_wb + 1 : MAX_WAIT) : 0;
        x_enb = g_hr || g_cr;
        if (x_enb) begin
            ret_t r;
            x_addrb = g_hr ? i_h_rd_addr : i_c_rd_addr;
            r.due = cyc + RD_LAT + 1;
            r.core = g_cr;
            r.data = ref_mem[x_addrb];
            ret_q.push_back(r);
        end
        x_ena = g_hw || g_cw;
        if (x_ena) begin
            x_addra = g_hw ? i_h_wr_addr : i_c_wr_addr;
            x_dina  = g_hw ? i_h_wr_data : i_c_wr_data;
            ref_mem[x_addra] = x_dina;
        end
        m_owner = i_core_busy;
    endtask

    task automatic cycle_step();
        eval();
        tick();
    endtask

    task automatic drive_rand(input int pct);
        if (!(i_h_wr_req && !g_hw)) begin
            i_h_wr_req = ($urandom_range(0, 99) < pct);
            i_h_wr_addr = ADDR_W'($urandom_range(0, 15));
            i_h_wr_data = rnd_data();
        end
        if (!(i_c_wr_req && !g_cw)) begin
            i_c_wr_req = ($urandom_range(0, 99) < pct);
            i_c_wr_addr = ADDR_W'($urandom_range(0, 15));
            i_c_wr_data = rnd_data();
        end
        if (!(i_h_rd_req && !g_hr)) begin
            i_h_rd_req = ($urandom_range(0, 99) < pct);
            i_h_rd_addr = ADDR_W'($urandom_range(0, 15));
        end
        if (!(i_c_rd_req && !g_cr)) begin
            i_c_rd_req = ($urandom_range(0, 99) < pct);
            i_c_rd_addr = ADDR_W'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 9) == 0) i_core_busy = ~i_core_busy;
    endtask

    initial begin
        int first_gnt;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            bram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        model_reset();

        // Reset held with requests pending: no grants, all outputs low.
        i_h_wr_req = 1; i_c_rd_req = 1; i_h_rd_req = 1; i_c_wr_req = 1;
        eval();
        tick();
        eval();
        set_idle();
        #2 i_rst = 1;
        tick();

        // Host write 0x05 <= 0x123, then host read of 0x05 back.
        i_h_wr_req = 1; i_h_wr_addr = 8'h05; i_h_wr_data = DATA_W'(12'h123);
        cycle_step();
        set_idle();
        i_h_rd_req = 1; i_h_rd_addr = 8'h05;
        cycle_step();
        set_idle();
        repeat (3) cycle_step();

        // Core owner: core reads win until core drops its request.
        i_core_busy = 1;
        cycle_step();
        i_h_rd_req = 1; i_h_rd_addr = 8'h05;
        for (int i = 0; i < 4; i++) begin
            i_c_rd_req = 1; i_c_rd_addr = ADDR_W'(i);
            cycle_step();
        end
        i_c_rd_req = 0;
        cycle_step();
        set_idle();
        repeat (3) cycle_step();

        // Host read in flight while ownership moves to core.
        i_core_busy = 0;
        cycle_step();
        i_h_rd_req = 1; i_h_rd_addr = 8'h05;
        cycle_step();
        set_idle();
        i_core_busy = 1;
        repeat (4) cycle_step();

        // Core write 0x10 and host read 0x20 under core ownership, same cycle.
        i_c_wr_req = 1; i_c_wr_addr = 8'h10; i_c_wr_data = rnd_data();
        i_h_rd_req = 1; i_h_rd_addr = 8'h20;
        cycle_step();
        set_idle();
        repeat (3) cycle_step();

        // Core reading continuously while the host read waits.
        first_gnt = 0;
        i_h_rd_req = 1; i_h_rd_addr = 8'h10;
        i_c_rd_req = 1; i_c_rd_addr = 8'h00;
        for (int i = 1; i <= 40; i++) begin
            eval();
            if (o_h_rd_gnt && first_gnt == 0) first_gnt = i;
            if (g_hr) i_h_rd_req = 0;
            tick();
            if (g_cr) i_c_rd_addr = ADDR_W'($urandom_range(0, 255));
        end
        check("starve_first_gnt", first_gnt, GUARD ? 16 : 0);
        set_idle();
        repeat (3) cycle_step();

        // Random traffic with random ownership flips.
        for (int i = 0; i < 1500; i++) begin
            drive_rand((i < 750) ? 60 : 90);
            cycle_step();
        end

        // Reset asserted while a host read is in flight.
        set_idle();
        repeat (3) cycle_step();
        i_core_busy = 0;
        repeat (2) cycle_step();
        i_h_rd_req = 1; i_h_rd_addr = 8'h05;
        eval();
        @(posedge i_clk);
        cyc++;
        set_idle();
        #1 i_rst = 0;
        #1;
        model_reset();
        check("rst_ena", o_bram_ena, 1'b0);
        check("rst_enb", o_bram_enb, 1'b0);
        check("rst_addrb", o_bram_addrb, '0);
        check("rst_h_valid", o_h_rd_valid, 1'b0);
        check("rst_h_data", o_h_rd_data, '0);
        check("rst_owner", o_owner, 1'b0);
        i_h_rd_req = 1;
        eval();
        set_idle();
        tick();
        eval();
        tick();
        i_rst = 1;
        repeat (5) cycle_step();
        check("queue_drained", ret_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
